mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one main-memory port between I-cache and D-cache
// One block transfer at a time; each transfer ends with a one-cycle RELEASE that unstalls its owner.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WRITEDATA,
    input  logic [DATA_W-1:0] M_READDATA,
    input  logic              M_BUSYWAIT
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              owner;
    logic              last_grant;
    logic              first_cycle;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant_valid;
    logic grant_side;
    logic in_serve;
    logic complete;

    assign i_req    = I_READ;
    assign d_req    = D_READ | D_WRITE;
    assign in_serve = (state == SERVE_I) || (state == SERVE_D);

    // The first SERVE cycle never completes, so memory always sees the strobe for a full cycle.
    assign complete = in_serve && !first_cycle && !M_BUSYWAIT;

    always_comb begin
        grant_valid = i_req | d_req;
        grant_side  = SIDE_I;
        if (i_req && d_req) begin
            grant_side = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (d_req) begin
            grant_side = SIDE_D;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = (grant_side == SIDE_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (complete) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            owner       <= SIDE_I;
            last_grant  <= SIDE_I;
            first_cycle <= 1'b0;
            op_write    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_valid) begin
                owner       <= grant_side;
                last_grant  <= grant_side;
                first_cycle <= 1'b1;
                if (grant_side == SIDE_D) begin
                    // A write-back always goes ahead of the refill it accompanies.
                    op_write <= D_WRITE;
                    addr_q   <= D_ADDR;
                    wdata_q  <= D_WRITEDATA;
                end else begin
                    op_write <= 1'b0;
                    addr_q   <= I_ADDR;
                    wdata_q  <= '0;
                end
            end else if (in_serve) begin
                first_cycle <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            I_READDATA <= '0;
            D_READDATA <= '0;
        end else if (complete && !op_write) begin
            if (owner == SIDE_I) begin
                I_READDATA <= M_READDATA;
            end else begin
                D_READDATA <= M_READDATA;
            end
        end
    end

    assign M_READ      = in_serve && !op_write;
    assign M_WRITE     = in_serve && op_write;
    assign M_ADDR      = addr_q;
    assign M_WRITEDATA = wdata_q;

    assign I_BUSYWAIT = i_req && !(state == RELEASE && owner == SIDE_I);
    assign D_BUSYWAIT = d_req && !(state == RELEASE && owner == SIDE_D);

endmodule
